// File: rtl/cnn_pool_pkg.sv
// Shared definitions for the pooling blocks: FSM states, window geometry
// and the channel-counter width rule.
package cnn_pool_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pool_state_t;

    // 2x2 window, stride 2
    localparam int POOL_K = 2;
    localparam int POOL_S = 2;

    // Channel counter width: $clog2(ch), never narrower than one bit
    function automatic int cnt_width(input int ch);
        return (ch <= 1) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/pool_window_max.sv
// Combinational max of a 2x2 window; signed or unsigned compare.
module pool_window_max #(
    parameter int DATA_W = 1,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] y
);

    function automatic logic gt(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] z);
        if (SIGNED != 0) return $signed(x) > $signed(z);
        else             return x > z;
    endfunction

    logic [DATA_W-1:0] m_top;
    logic [DATA_W-1:0] m_bot;

    // Pairwise tree reduction of the four window elements
    always_comb begin
        m_top = gt(a, b) ? a : b;
        m_bot = gt(c, d) ? c : d;
        y     = gt(m_top, m_bot) ? m_top : m_bot;
    end

endmodule

// File: rtl/maxpooling_param_seq.sv
// Sequential 2x2/stride-2 max pooling: one channel per clock after capture.
module maxpooling_param_seq
    import cnn_pool_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int COLS   = 8,
    parameter int CH     = 4,
    parameter int SIGNED = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start_flag,
    input  logic [CH*2*COLS*DATA_W-1:0]       in,
    output logic [CH*(COLS/2)*DATA_W-1:0]     out,
    output logic                              busy,
    output logic                              end_flag
);

    localparam int HALF     = COLS / POOL_S;
    localparam int CW       = cnt_width(CH);
    localparam int ROW_W    = COLS * DATA_W;
    localparam int CH_IN_W  = POOL_K * ROW_W;
    localparam int CH_OUT_W = HALF * DATA_W;

    if (COLS < 2 || (COLS % 2) != 0 || CH < 1 || DATA_W < 1) begin : g_param_err
        $fatal(1, "maxpooling_param_seq: illegal parameters");
    end

    pool_state_t             state;
    pool_state_t             state_n;
    logic [CW-1:0]           ch_cnt;
    logic [CH*CH_IN_W-1:0]   cap;
    logic [CH_IN_W-1:0]      cur_ch;
    logic [CH_OUT_W-1:0]     res;
    logic                    load;
    logic                    wr;
    logic                    last;

    // Channel mux: select the captured rows of channel ch_cnt
    always_comb begin
        cur_ch = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (ch_cnt == CW'(i)) cur_ch = cap[i*CH_IN_W +: CH_IN_W];
        end
    end

    for (genvar j = 0; j < HALF; j++) begin : g_win
        pool_window_max #(
            .DATA_W (DATA_W),
            .SIGNED (SIGNED)
        ) u_win (
            .a (cur_ch[(POOL_S*j)*DATA_W         +: DATA_W]),
            .b (cur_ch[(POOL_S*j+1)*DATA_W       +: DATA_W]),
            .c (cur_ch[ROW_W + (POOL_S*j)*DATA_W   +: DATA_W]),
            .d (cur_ch[ROW_W + (POOL_S*j+1)*DATA_W +: DATA_W]),
            .y (res[j*DATA_W +: DATA_W])
        );
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and datapath strobes
    always_comb begin
        state_n = state;
        load    = 1'b0;
        wr      = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (start_flag) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                wr = 1'b1;
                if (ch_cnt == CW'(CH - 1)) begin
                    last    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture register, channel counter, result slices and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap      <= '0;
            ch_cnt   <= '0;
            out      <= '0;
            busy     <= 1'b0;
            end_flag <= 1'b0;
        end else begin
            end_flag <= last;
            if (load) begin
                cap    <= in;
                ch_cnt <= '0;
                busy   <= 1'b1;
            end
            if (wr) begin
                for (int unsigned i = 0; i < CH; i++) begin
                    if (ch_cnt == CW'(i)) out[i*CH_OUT_W +: CH_OUT_W] <= res;
                end
                ch_cnt <= last ? '0 : ch_cnt + 1'b1;
                if (last) busy <= 1'b0;
            end
        end
    end

endmodule
